ram_arbiter: RTL and testbench

- Two-requester arbiter that shares one syn_ram instance (sync write, async read) between a CPU-side port (p0) and a DMA/peripheral port (p1).
- Grants at most one access per clock, round-robin, and returns registered read data with a valid strobe.
- Sits between the core's memory interface and the on-chip RAM, so both masters can use one RAM without external muxing.

---
 rtl/ram_arb_pkg.sv | 11 +
 rtl/ram_arbiter_syn_ram.sv | 27 ++
 rtl/ram_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: port indices and the
// select type used for the grant index and the round-robin history.
package ram_arb_pkg;

   // One bit is enough to name either of the two requesters
   typedef logic arb_sel_t;

   localparam arb_sel_t PORT0 = 1'b0;
   localparam arb_sel_t PORT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_syn_ram.sv
// Single-port-style on-chip RAM with a synchronous write port and an
// asynchronous (combinational) read port. Contents are never cleared.
module syn_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_COUNT = 256
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr_out,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [DATA_COUNT];

   // Store the write data at the clock edge when a write is enabled
   always_ff @(posedge clk) begin
      if (write_enable) begin
         mem[addr_in] <= data_in;
      end
   end

   assign data_out = mem[addr_out];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter sharing one syn_ram between a CPU port (p0) and a
// DMA/peripheral port (p1). One access is granted per clock; grants are
// combinational, reads return registered data with a one-cycle valid strobe.
// Optional macro RAM_ARB_FIXED_PRIO_EN: port 0 always wins contention
// (port 1 may starve). Default build uses round-robin.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_COUNT = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_ack,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata
);

   arb_sel_t              last_grant_q, last_grant_d;
   arb_sel_t              grant_sel;
   logic                  grant_valid;
   logic                  grant_we;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic                  p0_rvalid_q, p0_rvalid_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic                  p1_rvalid_q, p1_rvalid_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

   // Pick the winner for this cycle; nothing is granted while in reset
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = PORT0;
      if (!rst) begin
         if (p0_req && p1_req) begin
            grant_valid = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
            grant_sel   = PORT0;
`else
            grant_sel   = (last_grant_q == PORT0) ? PORT1 : PORT0;
`endif
         end else if (p0_req) begin
            grant_valid = 1'b1;
            grant_sel   = PORT0;
         end else if (p1_req) begin
            grant_valid = 1'b1;
            grant_sel   = PORT1;
         end
      end
   end

   assign p0_ack = grant_valid && (grant_sel == PORT0);
   assign p1_ack = grant_valid && (grant_sel == PORT1);

   // Steer the granted port's command onto the RAM; write only on a real grant
   always_comb begin
      ram_addr  = p0_addr;
      ram_wdata = p0_wdata;
      grant_we  = p0_we;
      if (grant_sel == PORT1) begin
         ram_addr  = p1_addr;
         ram_wdata = p1_wdata;
         grant_we  = p1_we;
      end
      ram_we = grant_valid && grant_we;
   end

   // Next-state for the grant history and the per-port read responses
   always_comb begin
      last_grant_d = last_grant_q;
      if (grant_valid) begin
         last_grant_d = grant_sel;
      end
      p0_rvalid_d = p0_ack && !grant_we;
      p1_rvalid_d = p1_ack && !grant_we;
      p0_rdata_d  = p0_rvalid_d ? ram_rdata : p0_rdata_q;
      p1_rdata_d  = p1_rvalid_d ? ram_rdata : p1_rdata_q;
   end

   // Register grant history and read responses; reset favours port 0 next
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= PORT1;
         p0_rvalid_q  <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rvalid_q  <= 1'b0;
         p1_rdata_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         p0_rvalid_q  <= p0_rvalid_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rvalid_q  <= p1_rvalid_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   assign p0_rvalid = p0_rvalid_q;
   assign p0_rdata  = p0_rdata_q;
   assign p1_rvalid = p1_rvalid_q;
   assign p1_rdata  = p1_rdata_q;

   syn_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_COUNT(DATA_COUNT)
   ) u_ram (
      .clk         (clk),
      .write_enable(ram_we),
      .addr_in     (ram_addr),
      .data_in     (ram_wdata),
      .addr_out    (ram_addr),
      .data_out    (ram_rdata)
   );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter. Inputs change on the falling
// edge; acks are sampled just after, registered outputs one edge later.
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       p0_req, p0_we, p1_req, p1_we;
   logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic       p0_ack, p0_rvalid, p1_ack, p1_rvalid;
   logic [7:0] p0_rdata, p1_rdata;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DATA_COUNT(256)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata)
   );

   // Expected preload value for the low burst addresses
   function automatic logic [7:0] burst_val(input int a);
      if (a == 1) return 8'h11;
      if (a == 2) return 8'h22;
      return 8'h40 + 8'(a);
   endfunction

   // Advance one clock: through the rising edge to the next falling edge
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Preload a word through port 1 (called while the arbiter is idle)
   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = a; p1_wdata = d;
      next_cycle();
      p1_req = 1'b0; p1_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h00; p0_wdata = 8'h00;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = 8'h00; p1_wdata = 8'h00;
      @(negedge clk);
      total++;
      if (p0_ack !== 1'b0) $display("[TB] FAIL reset_ack_suppressed: p0_ack=%b expected 0", p0_ack);
      else passed++;
      p0_req = 1'b0; p0_we = 1'b0;
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if ({p0_ack, p1_ack, p0_rvalid, p1_rvalid} !== 4'b0 || p0_rdata !== 8'h00 || p1_rdata !== 8'h00)
            $display("[TB] FAIL reset_idle%0d: ack=%b%b rvalid=%b%b rdata=%h/%h expected all 0",
                     i, p0_ack, p1_ack, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
         else passed++;
         next_cycle();
      end
   endtask

   task automatic test_single_port();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 8'hA5;
      #1;
      total++;
      if (p0_ack !== 1'b1) $display("[TB] FAIL single_write_ack: p0_ack=%b expected 1", p0_ack);
      else passed++;
      next_cycle();
      p0_we = 1'b0;
      #1;
      total++;
      if (p0_ack !== 1'b1 || p0_rvalid !== 1'b0)
         $display("[TB] FAIL single_read_ack: p0_ack=%b p0_rvalid=%b expected 1/0", p0_ack, p0_rvalid);
      else passed++;
      next_cycle();
      p0_req = 1'b0;
      #1;
      total++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 8'hA5)
         $display("[TB] FAIL single_read_data: rvalid=%b rdata=%h expected 1/a5", p0_rvalid, p0_rdata);
      else passed++;
      next_cycle();
      #1;
      total++;
      if (p0_rvalid !== 1'b0 || p0_rdata !== 8'hA5)
         $display("[TB] FAIL single_rdata_hold: rvalid=%b rdata=%h expected 0/a5", p0_rvalid, p0_rdata);
      else passed++;
   endtask

   task automatic test_contention();
      logic e0, e1, prev0, prev1;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h01;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
      prev0 = 1'b0; prev1 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            p0_req = 1'b0; p1_req = 1'b0;
         end
         #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
         e0 = (k < 4);
         e1 = 1'b0;
`else
         e0 = (k < 4) && (k % 2 == 0);
         e1 = (k < 4) && (k % 2 == 1);
`endif
         total++;
         if (p0_ack !== e0 || p1_ack !== e1)
            $display("[TB] FAIL contention_ack%0d: ack=%b%b expected %b%b", k, p0_ack, p1_ack, e0, e1);
         else passed++;
         total++;
         if (p0_rvalid !== prev0 || p1_rvalid !== prev1 ||
             (prev0 && p0_rdata !== 8'h11) || (prev1 && p1_rdata !== 8'h22))
            $display("[TB] FAIL contention_rd%0d: rvalid=%b%b rdata=%h/%h expected %b%b 11/22",
                     k, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, prev0, prev1);
         else passed++;
         prev0 = e0; prev1 = e1;
         next_cycle();
      end
   endtask

   task automatic test_cross_port();
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h80; p1_wdata = 8'h3C;
      #1;
      total++;
      if (p1_ack !== 1'b1 || p0_ack !== 1'b0)
         $display("[TB] FAIL cross_write_ack: ack=%b%b expected 01", p0_ack, p1_ack);
      else passed++;
      next_cycle();
      p1_req = 1'b0; p1_we = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h80;
      #1;
      total++;
      if (p0_ack !== 1'b1 || p1_rvalid !== 1'b0)
         $display("[TB] FAIL cross_read_ack: p0_ack=%b p1_rvalid=%b expected 1/0", p0_ack, p1_rvalid);
      else passed++;
      next_cycle();
      p0_req = 1'b0;
      #1;
      total++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 8'h3C || p1_rvalid !== 1'b0)
         $display("[TB] FAIL cross_read_data: p0 rvalid=%b rdata=%h p1_rvalid=%b expected 1/3c/0",
                  p0_rvalid, p0_rdata, p1_rvalid);
      else passed++;
      next_cycle();
   endtask

   task automatic test_reset_mid_access();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h20; p0_wdata = 8'hFF;
      rst = 1'b1;
      #1;
      total++;
      if (p0_ack !== 1'b0) $display("[TB] FAIL midreset_ack: p0_ack=%b expected 0", p0_ack);
      else passed++;
      next_cycle();
      rst = 1'b0;
      p0_we = 1'b0; p0_addr = 8'h01;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h02;
      #1;
      total++;
      if (p0_ack !== 1'b1 || p1_ack !== 1'b0)
         $display("[TB] FAIL midreset_first_grant: ack=%b%b expected 10", p0_ack, p1_ack);
      else passed++;
      next_cycle();
      p1_req = 1'b0;
      p0_addr = 8'h20;
      next_cycle();
      p0_req = 1'b0;
      #1;
      total++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 8'h00)
         $display("[TB] FAIL midreset_no_write: rvalid=%b rdata=%h expected 1/00", p0_rvalid, p0_rdata);
      else passed++;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      p1_req = 1'b1; p1_we = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k < 8) p1_addr = 8'(k);
         else p1_req = 1'b0;
         #1;
         total++;
         if (p1_ack !== (k < 8))
            $display("[TB] FAIL burst_ack%0d: p1_ack=%b expected %b", k, p1_ack, (k < 8));
         else passed++;
         if (k > 0) begin
            total++;
            if (p1_rvalid !== 1'b1 || p1_rdata !== burst_val(k - 1))
               $display("[TB] FAIL burst_data%0d: rvalid=%b rdata=%h expected 1/%h",
                        k - 1, p1_rvalid, p1_rdata, burst_val(k - 1));
            else passed++;
         end
         next_cycle();
      end
      #1;
      total++;
      if (p1_rvalid !== 1'b0) $display("[TB] FAIL burst_end: p1_rvalid=%b expected 0", p1_rvalid);
      else passed++;
   endtask

   initial begin
      test_reset();
      for (int a = 0; a < 8; a++) preload(8'(a), burst_val(a));
      preload(8'h20, 8'h00);
      test_single_port();
      test_contention();
      test_cross_port();
      test_reset_mid_access();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
